// File: rtl/primitive_group_fetch_pkg.sv
// Shared types for the primitive group fetch block.
//   BVH_Primitive        : one primitive record as stored in a RAM bank.
//   PrimFetchState       : request FSM states.
//   PrimFetchBeat        : one response beat (lanes, lane-valid mask, last tag).
package primitive_group_fetch_pkg;

  localparam int unsigned BVH_AABB_TEST_UNIT_SIZE   = 4;
  localparam int unsigned BVH_PRIMITIVE_INDEX_WIDTH = 16;
  localparam int unsigned BVH_PRIMITIVE_WIDTH       = 32;

  typedef logic [BVH_PRIMITIVE_WIDTH-1:0] BVH_Primitive;

  typedef enum logic [1:0] {
    PGF_Idle,
    PGF_Issue,
    PGF_Drain
  } PrimFetchState;

  typedef struct packed {
    BVH_Primitive [BVH_AABB_TEST_UNIT_SIZE-1:0] prim;
    logic [BVH_AABB_TEST_UNIT_SIZE-1:0]         mask;
    logic                                       last;
  } PrimFetchBeat;

endpackage

// File: rtl/primitive_group_fetch_if.sv
// Request/response bus between a ray/shadow unit and primitive_group_fetch.
//   req_valid/req_ready/req_start/req_end : group request handshake.
//   abort                                 : drop the remainder of the group.
//   rsp_valid/rsp_ready/rsp_prim/rsp_mask/rsp_last : beat stream.
// master = requester, slave = primitive_group_fetch.
interface primitive_group_fetch_if
  import primitive_group_fetch_pkg::*;
#(
  parameter int unsigned UNIT_SIZE = BVH_AABB_TEST_UNIT_SIZE,
  parameter int unsigned INDEX_W   = BVH_PRIMITIVE_INDEX_WIDTH
);

  logic                          req_valid;
  logic                          req_ready;
  logic [INDEX_W-1:0]            req_start;
  logic [INDEX_W-1:0]            req_end;
  logic                          abort;
  logic                          rsp_valid;
  logic                          rsp_ready;
  BVH_Primitive [UNIT_SIZE-1:0]  rsp_prim;
  logic [UNIT_SIZE-1:0]          rsp_mask;
  logic                          rsp_last;

  modport master (
    output req_valid, req_start, req_end, abort, rsp_ready,
    input  req_ready, rsp_valid, rsp_prim, rsp_mask, rsp_last
  );

  modport slave (
    input  req_valid, req_start, req_end, abort, rsp_ready,
    output req_ready, rsp_valid, rsp_prim, rsp_mask, rsp_last
  );

endinterface

// File: rtl/primitive_group_fetch_skid_fifo.sv
// Output beat buffer for primitive_group_fetch.
//   clk, reset : clock, asynchronous active-high reset.
//   push/push_beat : write a beat (ignored when full).
//   pop            : retire the head beat (ignored when empty).
//   flush          : drop all entries; wins over push/pop.
//   head/empty/count : head entry, empty flag, occupancy.
module prim_fetch_skid_fifo
  import primitive_group_fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter type         beat_t = PrimFetchBeat
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  beat_t                        push_beat,
  input  logic                         pop,
  input  logic                         flush,
  output beat_t                        head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  beat_t             mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_beat;
  end

endmodule

// File: rtl/primitive_group_fetch.sv
// Primitive group fetch: accepts one (start, end) primitive range, reads it
// from UNIT_SIZE-banked primitive RAM and streams UNIT_SIZE-wide beats back.
//   clk, reset  : clock, asynchronous active-high reset.
//   bus         : request/response bus (slave side), see primitive_group_fetch_if.
//   mem_rd_en   : RAM read strobe; mem_rd_addr holds one row per bank.
//   mem_rd_data : per-bank data, RAM_LATENCY cycles after mem_rd_en.
// Optional macro PRIM_GROUP_FETCH_STATS_EN adds saturating counters
//   stat_beats, stat_stall, stat_aborts.
module primitive_group_fetch
  import primitive_group_fetch_pkg::*;
#(
  parameter int unsigned UNIT_SIZE   = BVH_AABB_TEST_UNIT_SIZE,
  parameter int unsigned INDEX_W     = BVH_PRIMITIVE_INDEX_WIDTH,
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned BUF_DEPTH   = RAM_LATENCY + 2
) (
  input  logic                                                clk,
  input  logic                                                reset,
  primitive_group_fetch_if.slave                              bus,
  output logic                                                mem_rd_en,
  output logic [UNIT_SIZE-1:0][INDEX_W-$clog2(UNIT_SIZE)-1:0] mem_rd_addr,
  input  BVH_Primitive [UNIT_SIZE-1:0]                        mem_rd_data
`ifdef PRIM_GROUP_FETCH_STATS_EN
  ,
  output logic [31:0]                                         stat_beats,
  output logic [31:0]                                         stat_stall,
  output logic [15:0]                                         stat_aborts
`endif
);

  localparam int unsigned LOG_U = $clog2(UNIT_SIZE);
  localparam int unsigned ROW_W = INDEX_W - LOG_U;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(RAM_LATENCY + 1);
  localparam int unsigned LAST  = RAM_LATENCY - 1;

  typedef struct packed {
    BVH_Primitive [UNIT_SIZE-1:0] prim;
    logic [UNIT_SIZE-1:0]         mask;
    logic                         last;
  } beat_t;

  PrimFetchState         state_q, state_d;
  logic [INDEX_W-1:0]    base_q, base_d;
  logic [INDEX_W-1:0]    end_q, end_d;
  logic [INDEX_W:0]      base_x, end_x;
  logic [ROW_W-1:0]      base_row;
  logic [LOG_U-1:0]      base_lo;
  logic [UNIT_SIZE-1:0]  lane_mask;
  logic                  issue_last;
  logic                  credit;
  logic                  issue;
  logic                  empty_req;
  logic                  abort_eff;

  // Tag pipe travelling beside the RAM read; keep=0 marks an aborted read.
  logic [RAM_LATENCY-1:0]                p_valid, p_keep, p_last;
  logic [RAM_LATENCY-1:0][UNIT_SIZE-1:0] p_mask;
  logic [RAM_LATENCY-1:0][LOG_U-1:0]     p_rot;
  logic [OUT_W-1:0]                      outstanding;

  beat_t                 ret_beat, push_beat, head;
  logic                  push, pop, buf_empty;
  logic [CNT_W-1:0]      buf_count;

  assign abort_eff = bus.abort && (state_q != PGF_Idle);
  assign credit    = (32'(outstanding) + 32'(buf_count)) < BUF_DEPTH;

  always_comb begin
    outstanding = '0;
    for (int unsigned k = 0; k < RAM_LATENCY; k++)
      outstanding = outstanding + OUT_W'(p_valid[k]);
  end

  // Lane/bank arithmetic. Compares use INDEX_W+1 bits so lanes that wrap
  // past 2^INDEX_W fall outside the range instead of aliasing to low indices.
  always_comb begin
    base_x     = {1'b0, base_q};
    end_x      = {1'b0, end_q};
    base_row   = base_q[INDEX_W-1:LOG_U];
    base_lo    = base_q[LOG_U-1:0];
    issue_last = (base_x + (INDEX_W+1)'(UNIT_SIZE)) >= end_x;
    for (int unsigned i = 0; i < UNIT_SIZE; i++)
      lane_mask[i] = (base_x + (INDEX_W+1)'(i)) < end_x;
    // Banks below the base offset hold the wrapped lanes of the next row.
    for (int unsigned b = 0; b < UNIT_SIZE; b++)
      mem_rd_addr[b] = (LOG_U'(b) < base_lo) ? base_row + ROW_W'(1) : base_row;
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    end_d     = end_q;
    issue     = 1'b0;
    empty_req = 1'b0;
    case (state_q)
      PGF_Idle: begin
        if (bus.req_valid) begin
          base_d = bus.req_start;
          end_d  = bus.req_end;
          if (bus.req_end <= bus.req_start) begin
            empty_req = 1'b1;
            state_d   = PGF_Drain;
          end else begin
            state_d = PGF_Issue;
          end
        end
      end
      PGF_Issue: begin
        if (credit) begin
          issue  = 1'b1;
          base_d = base_q + INDEX_W'(UNIT_SIZE);
          if (issue_last) state_d = PGF_Drain;
        end
      end
      PGF_Drain: begin
        if (buf_empty && outstanding == '0) state_d = PGF_Idle;
      end
      default: state_d = PGF_Idle;
    endcase
    if (abort_eff) begin
      issue   = 1'b0;
      base_d  = base_q;
      state_d = PGF_Drain;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PGF_Idle;
      base_q  <= '0;
      end_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      end_q   <= end_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid <= '0;
      p_keep  <= '0;
      p_last  <= '0;
      p_mask  <= '0;
      p_rot   <= '0;
    end else begin
      p_valid[0] <= issue;
      p_keep[0]  <= issue;
      p_last[0]  <= issue_last;
      p_mask[0]  <= lane_mask;
      p_rot[0]   <= base_lo;
      for (int unsigned k = 1; k < RAM_LATENCY; k++) begin
        p_valid[k] <= p_valid[k-1];
        p_keep[k]  <= p_keep[k-1] && !abort_eff;
        p_last[k]  <= p_last[k-1];
        p_mask[k]  <= p_mask[k-1];
        p_rot[k]   <= p_rot[k-1];
      end
    end
  end

  // Rotate bank data so lane i carries primitive base+i.
  always_comb begin
    ret_beat.mask = p_mask[LAST];
    ret_beat.last = p_last[LAST];
    for (int unsigned i = 0; i < UNIT_SIZE; i++)
      ret_beat.prim[i] = mem_rd_data[p_rot[LAST] + LOG_U'(i)];
  end

  // An empty group pushes its single terminating beat straight from IDLE;
  // the tag pipe is always idle then, so the two push sources never collide.
  always_comb begin
    push_beat = ret_beat;
    if (empty_req) begin
      push_beat.prim = '0;
      push_beat.mask = '0;
      push_beat.last = 1'b1;
    end
  end

  assign push = !abort_eff && (empty_req || (p_valid[LAST] && p_keep[LAST]));
  assign pop  = bus.rsp_valid && bus.rsp_ready;

  prim_fetch_skid_fifo #(
    .DEPTH  (BUF_DEPTH),
    .beat_t (beat_t)
  ) u_skid_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_beat (push_beat),
    .pop       (pop),
    .flush     (abort_eff),
    .head      (head),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign bus.req_ready = (state_q == PGF_Idle);
  assign bus.rsp_valid = !buf_empty;
  assign bus.rsp_prim  = head.prim;
  assign bus.rsp_mask  = buf_empty ? '0 : head.mask;
  assign bus.rsp_last  = !buf_empty && head.last;
  assign mem_rd_en     = issue;

`ifdef PRIM_GROUP_FETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_beats  <= '0;
      stat_stall  <= '0;
      stat_aborts <= '0;
    end else begin
      if (pop && stat_beats != '1)
        stat_beats <= stat_beats + 32'd1;
      if (bus.rsp_valid && !bus.rsp_ready && stat_stall != '1)
        stat_stall <= stat_stall + 32'd1;
      // An abort that only coincides with the final beat's handshake drops nothing.
      if (abort_eff && !(pop && head.last) && stat_aborts != '1)
        stat_aborts <= stat_aborts + 16'd1;
    end
  end
`endif

endmodule
